// File: rtl/mw_writeback.sv
// -----------------------------------------------------------------------------
// mw_writeback
//   Write side of the register-file write port. Holds the MEM/WB stage register,
//   formats load data (byte/half extraction with sign/zero extension), and
//   merges results from the multi-cycle mul/div unit through a small FIFO.
//   The registered MW_RegWrite/MW_WBAddr/MW_WBData triple drives the single
//   register-file write port and also feeds the forwarding unit.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   stall, flush      upstream EX/MEM held / kill the entering instruction
//   EM_*              EX/MEM stage outputs (valid, write enable, address,
//                     writeback select, ALU result, PC+8, load type, offset)
//   DM_RData          data-memory read word for the instruction in MEM
//   MD_valid/WBAddr/WBData  mul/div result offer
//   MD_ready          FIFO can accept (registered, = !full)
//   aux_hold          FIFO full: asks upstream to stall so the head drains
//   MW_valid          MW slot occupied
//   MW_RegWrite/WBAddr/WBData  register-file write port (registered)
// -----------------------------------------------------------------------------
module mw_writeback #(
  parameter int AUX_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        EM_valid,
  input  logic        EM_RegWrite,
  input  logic [4:0]  EM_WBAddr,
  input  logic [1:0]  EM_WBSel,
  input  logic [31:0] EM_ALUOut,
  input  logic [31:0] EM_PC8,
  input  logic [2:0]  EM_LoadType,
  input  logic [1:0]  EM_ByteOff,
  input  logic [31:0] DM_RData,
  input  logic        MD_valid,
  input  logic [4:0]  MD_WBAddr,
  input  logic [31:0] MD_WBData,
  output logic        MD_ready,
  output logic        aux_hold,
  output logic        MW_valid,
  output logic        MW_RegWrite,
  output logic [4:0]  MW_WBAddr,
  output logic [31:0] MW_WBData
);

  localparam int PW = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(AUX_DEPTH);

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_LINK = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_H  = 3'b001,
    LD_HU = 3'b010,
    LD_B  = 3'b011,
    LD_BU = 3'b100
  } load_type_e;

  // ---------------------------------------------------------------------------
  // Load formatting (little-endian). For halfwords only off[1] selects the
  // lane; off[0] is ignored.
  // ---------------------------------------------------------------------------
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [31:0] pipe_data;

  assign ld_byte = DM_RData[{EM_ByteOff, 3'b000} +: 8];
  assign ld_half = DM_RData[{EM_ByteOff[1], 4'b0000} +: 16];

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned; an unassigned path would infer a latch.
  always_comb begin
    load_data = DM_RData;
    case (load_type_e'(EM_LoadType))
      LD_H:    load_data = {{16{ld_half[15]}}, ld_half};
      LD_HU:   load_data = {16'h0000, ld_half};
      LD_B:    load_data = {{24{ld_byte[7]}}, ld_byte};
      LD_BU:   load_data = {24'h000000, ld_byte};
      default: load_data = DM_RData;
    endcase
  end

  always_comb begin
    pipe_data = EM_ALUOut;
    case (wb_sel_e'(EM_WBSel))
      WB_LOAD: pipe_data = load_data;
      WB_LINK: pipe_data = EM_PC8;
      default: pipe_data = EM_ALUOut;  // ALU and the reserved encoding
    endcase
  end

  // ---------------------------------------------------------------------------
  // Arbitration: a live pipeline write always wins the port; the FIFO head is
  // only popped in a cycle the pipeline leaves free (bubble or non-writing op).
  // ---------------------------------------------------------------------------
  logic          pipe_live;
  logic          pipe_wr;
  logic          push;
  logic          pop;
  logic          full;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  logic [4:0]  aux_addr [AUX_DEPTH];
  logic [31:0] aux_data [AUX_DEPTH];
  logic [4:0]  head_addr;
  logic [31:0] head_data;

  assign pipe_live = EM_valid & ~stall & ~flush;
  assign pipe_wr   = pipe_live & EM_RegWrite & (EM_WBAddr != 5'd0);
  assign push      = MD_valid & ~full;
  assign pop       = ~pipe_wr & (count != '0);
  assign head_addr = aux_addr[rd_ptr];
  assign head_data = aux_data[rd_ptr];

  // Push while full is impossible (MD_ready is low), so simultaneous push and
  // pop never exceed capacity even though MD_ready lags a pop by one cycle.
  always_comb begin
    count_next = count;
    if (push && !pop)      count_next = count + 1'b1;
    else if (pop && !push) count_next = count - 1'b1;
  end

  // NOTE: the FIFO storage has no reset; only pointers and count are reset,
  // which is enough to make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (push) begin
      aux_addr[wr_ptr] <= MD_WBAddr;
      aux_data[wr_ptr] <= MD_WBData;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;  // power-of-2 depth: natural wrap
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == FULL_COUNT);
    end
  end

  assign MD_ready = ~full;
  assign aux_hold = full;

  // ---------------------------------------------------------------------------
  // MEM/WB output register. Address/data are zeroed when nothing is written so
  // the forwarding unit never sees a stale triple.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      MW_valid    <= 1'b0;
      MW_RegWrite <= 1'b0;
      MW_WBAddr   <= 5'd0;
      MW_WBData   <= 32'd0;
    end else if (pipe_wr) begin
      MW_valid    <= 1'b1;
      MW_RegWrite <= 1'b1;
      MW_WBAddr   <= EM_WBAddr;
      MW_WBData   <= pipe_data;
    end else if (pop) begin
      MW_valid    <= 1'b1;
      MW_RegWrite <= (head_addr != 5'd0);
      MW_WBAddr   <= head_addr;
      MW_WBData   <= head_data;
    end else begin
      MW_valid    <= pipe_live;
      MW_RegWrite <= 1'b0;
      MW_WBAddr   <= 5'd0;
      MW_WBData   <= 32'd0;
    end
  end

endmodule

// File: tb/tb_mw_writeback.sv
// -----------------------------------------------------------------------------
// tb_mw_writeback
//   Self-checking bench for mw_writeback: reset, a table of single-cycle
//   vectors, stall/flush sequences, the mul/div merge scenario, a randomized
//   run with a mid-run reset, all against a queue-based reference model.
// -----------------------------------------------------------------------------
module tb_mw_writeback;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush;
  logic        EM_valid, EM_RegWrite;
  logic [4:0]  EM_WBAddr;
  logic [1:0]  EM_WBSel;
  logic [31:0] EM_ALUOut, EM_PC8;
  logic [2:0]  EM_LoadType;
  logic [1:0]  EM_ByteOff;
  logic [31:0] DM_RData;
  logic        MD_valid;
  logic [4:0]  MD_WBAddr;
  logic [31:0] MD_WBData;
  logic        MD_ready, aux_hold;
  logic        MW_valid, MW_RegWrite;
  logic [4:0]  MW_WBAddr;
  logic [31:0] MW_WBData;

  mw_writeback #(.AUX_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .EM_valid(EM_valid), .EM_RegWrite(EM_RegWrite), .EM_WBAddr(EM_WBAddr),
    .EM_WBSel(EM_WBSel), .EM_ALUOut(EM_ALUOut), .EM_PC8(EM_PC8),
    .EM_LoadType(EM_LoadType), .EM_ByteOff(EM_ByteOff), .DM_RData(DM_RData),
    .MD_valid(MD_valid), .MD_WBAddr(MD_WBAddr), .MD_WBData(MD_WBData),
    .MD_ready(MD_ready), .aux_hold(aux_hold), .MW_valid(MW_valid),
    .MW_RegWrite(MW_RegWrite), .MW_WBAddr(MW_WBAddr), .MW_WBData(MW_WBData)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of pending mul/div results plus the writeback
  // rules expressed with plain arithmetic.
  // ---------------------------------------------------------------------------
  typedef struct { logic [4:0] addr; logic [31:0] data; } md_entry_t;
  md_entry_t q[$];

  function automatic logic [31:0] ref_data(input logic [1:0] sel, input logic [31:0] alu,
                                           input logic [31:0] pc8, input logic [2:0] lt,
                                           input logic [1:0] off, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * off)) & 32'hFF;
    h = (rd >> (off[1] ? 16 : 0)) & 32'hFFFF;
    if (sel == 2'b10) return pc8;
    if (sel != 2'b01) return alu;
    case (lt)
      3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd2: return h;
      3'd3: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      default: return rd;
    endcase
  endfunction

  // One clock: predict from current inputs and model state, advance, compare.
  task automatic step(input string tag);
    bit pw, pop, push, e_valid, e_we;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    md_entry_t ent;
    pw   = EM_valid && EM_RegWrite && (EM_WBAddr != 0) && !stall && !flush;
    push = MD_valid && (q.size() < DEPTH);
    pop  = !pw && (q.size() > 0);
    e_addr = 0; e_data = 0; e_we = 0;
    if (pw) begin
      e_valid = 1; e_we = 1; e_addr = EM_WBAddr;
      e_data = ref_data(EM_WBSel, EM_ALUOut, EM_PC8, EM_LoadType, EM_ByteOff, DM_RData);
    end else if (pop) begin
      e_valid = 1; e_we = (q[0].addr != 0); e_addr = q[0].addr; e_data = q[0].data;
    end else begin
      e_valid = EM_valid && !stall && !flush;
    end
    if (pop) void'(q.pop_front());
    if (push) begin ent.addr = MD_WBAddr; ent.data = MD_WBData; q.push_back(ent); end
    @(posedge clk); #1;
    check({tag, ".valid"}, {31'd0, MW_valid}, {31'd0, e_valid});
    check({tag, ".we"}, {31'd0, MW_RegWrite}, {31'd0, e_we});
    if (e_we) begin
      check({tag, ".addr"}, {27'd0, MW_WBAddr}, {27'd0, e_addr});
      check({tag, ".data"}, MW_WBData, e_data);
    end
    check({tag, ".md_ready"}, {31'd0, MD_ready}, {31'd0, q.size() < DEPTH});
    check({tag, ".aux_hold"}, {31'd0, aux_hold}, {31'd0, q.size() >= DEPTH});
  endtask

  task automatic idle_inputs();
    stall = 0; flush = 0; EM_valid = 0; EM_RegWrite = 0; EM_WBAddr = 0;
    EM_WBSel = 0; EM_ALUOut = 0; EM_PC8 = 0; EM_LoadType = 0; EM_ByteOff = 0;
    DM_RData = 0; MD_valid = 0; MD_WBAddr = 0; MD_WBData = 0;
  endtask

  task automatic random_inputs();
    EM_valid = 1'($urandom); EM_RegWrite = 1'($urandom); EM_WBAddr = 5'($urandom);
    EM_WBSel = 2'($urandom); EM_ALUOut = $urandom; EM_PC8 = $urandom;
    EM_LoadType = 3'($urandom); EM_ByteOff = 2'($urandom); DM_RData = $urandom;
    MD_valid = 1'($urandom); MD_WBAddr = 5'($urandom); MD_WBData = $urandom;
    flush = ($urandom_range(0, 7) == 0);
  endtask

  typedef struct {
    logic        valid, we;
    logic [4:0]  addr;
    logic [1:0]  sel;
    logic [31:0] alu, pc8;
    logic [2:0]  lt;
    logic [1:0]  off;
    logic [31:0] rd;
    logic        exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[15];
  md_entry_t md_src[3];
  md_entry_t seen[$];

  initial begin
    int writes;
    int idx;
    vecs[0]  = '{1, 1, 5'd5,  2'b00, 32'h1234, 0, 3'd0, 2'd0, 0, 1, 5'd5, 32'h0000_1234};
    vecs[1]  = '{1, 1, 5'd0,  2'b00, 32'h1234, 0, 3'd0, 2'd0, 0, 0, 5'd0, 32'h0};
    vecs[2]  = '{1, 1, 5'd3,  2'b01, 0, 0, 3'd3, 2'd0, 32'h80F0_7F81, 1, 5'd3, 32'hFFFF_FF81};
    vecs[3]  = '{1, 1, 5'd4,  2'b01, 0, 0, 3'd4, 2'd3, 32'h80F0_7F81, 1, 5'd4, 32'h0000_0080};
    vecs[4]  = '{1, 1, 5'd6,  2'b01, 0, 0, 3'd1, 2'd2, 32'h80F0_7F81, 1, 5'd6, 32'hFFFF_80F0};
    vecs[5]  = '{1, 1, 5'd7,  2'b01, 0, 0, 3'd2, 2'd0, 32'h80F0_7F81, 1, 5'd7, 32'h0000_7F81};
    vecs[6]  = '{1, 1, 5'd8,  2'b01, 0, 0, 3'd1, 2'd3, 32'h80F0_7F81, 1, 5'd8, 32'hFFFF_80F0};
    vecs[7]  = '{1, 1, 5'd9,  2'b01, 0, 0, 3'd0, 2'd2, 32'h80F0_7F81, 1, 5'd9, 32'h80F0_7F81};
    vecs[8]  = '{1, 1, 5'd10, 2'b01, 0, 0, 3'd7, 2'd1, 32'h80F0_7F81, 1, 5'd10, 32'h80F0_7F81};
    vecs[9]  = '{1, 1, 5'd31, 2'b10, 32'h5, 32'h0040_0008, 3'd0, 2'd0, 0, 1, 5'd31, 32'h0040_0008};
    vecs[10] = '{1, 1, 5'd11, 2'b11, 32'hDEAD, 32'h9, 3'd0, 2'd0, 0, 1, 5'd11, 32'h0000_DEAD};
    vecs[11] = '{1, 0, 5'd12, 2'b00, 32'h77, 0, 3'd0, 2'd0, 0, 0, 5'd0, 32'h0};
    vecs[12] = '{1, 1, 5'd13, 2'b01, 0, 0, 3'd3, 2'd1, 32'h80F0_7F81, 1, 5'd13, 32'h0000_007F};
    vecs[13] = '{1, 1, 5'd14, 2'b01, 0, 0, 3'd4, 2'd2, 32'h80F0_7F81, 1, 5'd14, 32'h0000_00F0};
    vecs[14] = '{0, 1, 5'd15, 2'b00, 32'h55, 0, 3'd0, 2'd0, 0, 0, 5'd0, 32'h0};
    md_src[0] = '{5'd20, 32'hA000_0001};
    md_src[1] = '{5'd21, 32'hA000_0002};
    md_src[2] = '{5'd22, 32'hA000_0003};

    // Reset held with random inputs.
    rst_n = 0;
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      random_inputs();
      stall = 1'($urandom);
      @(posedge clk); #1;
      check("rst.valid", {31'd0, MW_valid}, 0);
      check("rst.we", {31'd0, MW_RegWrite}, 0);
      check("rst.addr", {27'd0, MW_WBAddr}, 0);
      check("rst.data", MW_WBData, 0);
      check("rst.md_ready", {31'd0, MD_ready}, 1);
      check("rst.aux_hold", {31'd0, aux_hold}, 0);
    end
    idle_inputs();
    rst_n = 1;
    step("idle");

    // Single-cycle vector table.
    for (int i = 0; i < 15; i++) begin
      EM_valid = vecs[i].valid; EM_RegWrite = vecs[i].we; EM_WBAddr = vecs[i].addr;
      EM_WBSel = vecs[i].sel; EM_ALUOut = vecs[i].alu; EM_PC8 = vecs[i].pc8;
      EM_LoadType = vecs[i].lt; EM_ByteOff = vecs[i].off; DM_RData = vecs[i].rd;
      step($sformatf("vec%0d", i));
      check($sformatf("vec%0d.tbl_we", i), {31'd0, MW_RegWrite}, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        check($sformatf("vec%0d.tbl_addr", i), {27'd0, MW_WBAddr}, {27'd0, vecs[i].exp_addr});
        check($sformatf("vec%0d.tbl_data", i), MW_WBData, vecs[i].exp_data);
      end
    end

    // Stall for 3 cycles: exactly one write, after release.
    idle_inputs();
    EM_valid = 1; EM_RegWrite = 1; EM_WBAddr = 5'd7; EM_ALUOut = 32'h77;
    writes = 0;
    stall = 1;
    for (int i = 0; i < 3; i++) begin step("stall_hold"); writes += int'(MW_RegWrite); end
    check("stall.none_while_held", writes, 0);
    stall = 0;
    step("stall_release"); writes += int'(MW_RegWrite);
    EM_valid = 0;
    step("stall_after"); writes += int'(MW_RegWrite);
    check("stall.once", writes, 1);

    // Flush kills the write, with or without stall.
    EM_valid = 1; writes = 0;
    flush = 1; stall = 1; step("flush_stall"); writes += int'(MW_RegWrite);
    stall = 0; step("flush"); writes += int'(MW_RegWrite);
    check("flush.none", writes, 0);
    idle_inputs();
    step("idle2");

    // Mul/div merge while the pipeline writes every cycle; upstream stalls on full.
    idx = 0;
    for (int c = 0; c < 20; c++) begin
      bit accepted;
      EM_valid = 1; EM_RegWrite = 1; EM_WBAddr = 5'((c % 5) + 1); EM_ALUOut = 32'(c);
      EM_WBSel = 0;
      stall = (q.size() >= DEPTH);
      MD_valid = (idx < 3);
      if (idx < 3) begin MD_WBAddr = md_src[idx].addr; MD_WBData = md_src[idx].data; end
      accepted = MD_valid && (q.size() < DEPTH);
      if (c >= 14) EM_valid = 0;  // let the last entry drain
      step($sformatf("merge%0d", c));
      if (accepted) idx++;
      if (c == 1) begin
        check("merge.ready_low_after2", {31'd0, MD_ready}, 0);
        check("merge.aux_hold_after2", {31'd0, aux_hold}, 1);
      end
      if (MW_RegWrite && MW_WBAddr >= 5'd20) seen.push_back('{MW_WBAddr, MW_WBData});
    end
    check("merge.all_accepted", idx, 3);
    check("merge.pop_count", seen.size(), 3);
    for (int i = 0; i < 3 && i < seen.size(); i++) begin
      check($sformatf("merge.pop%0d_addr", i), {27'd0, seen[i].addr}, {27'd0, md_src[i].addr});
      check($sformatf("merge.pop%0d_data", i), seen[i].data, md_src[i].data);
    end
    idle_inputs();
    step("idle3");

    // Randomized run with a mid-run reset.
    for (int c = 0; c < 400; c++) begin
      random_inputs();
      stall = (q.size() >= DEPTH) || ($urandom_range(0, 4) == 0);
      step("rand");
      if (c == 200) begin
        rst_n = 0; #1;
        check("midrst.we", {31'd0, MW_RegWrite}, 0);
        check("midrst.valid", {31'd0, MW_valid}, 0);
        check("midrst.md_ready", {31'd0, MD_ready}, 1);
        q.delete();
        @(posedge clk); #1;
        rst_n = 1;
        idle_inputs();
        step("midrst_idle");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
